seg_p2s_stream: RTL and testbench
=================================

# seg_p2s_stream

Parametrised parallel-to-serial transmitter for the board's shift-register-driven seven-segment display chain. It takes a WIDTH-bit segment pattern, snapshots it, and shifts it out with a registered, glitch-free serial clock at a programmable rate, followed by a latch strobe. Transfers start on request or automatically when the input changes. A change that arrives mid-transfer is queued and sent next, never lost. It sits between the display-pattern logic and the SEGCLK/SEGDT/SEGCLR/SEGEN board pins.

## Interface
- WIDTH, 64: bits per transfer (≥2).
- DIV, 1: serial half-period in clk cycles (≥1).
- MSB_FIRST, 1: 1 sends data[WIDTH-1] first; 0 sends data[0] first.
- AUTO, 1: 1 starts a transfer whenever data differs from the last value sent; 0 starts only on start.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data  in  WIDTH  pattern to send; sampled only at load.
- start  in  1  transfer request; level-sampled each cycle; valid in both modes.
- sclk  out  1  serial clock, registered; the external register captures on its rising edge.
- sdata  out  1  serial data, registered.
- sclr  out  1  active-low clear for the external chain.
- sen  out  1  latch/enable strobe, active-high.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse at transfer end.

## Operation
- States: IDLE, SHIFT, LATCH.
- Request: req = start | (AUTO & (data != last_sent)).
- IDLE with req at edge k:
  - Load the shift register, last_sent and bit counter from data; clear pending.
  - Go to SHIFT.
  - From k+1: busy=1, sclk=0, sdata = first bit.
- SHIFT, each bit has two phases:
  - Low phase, DIV cycles: sclk=0, sdata holds the bit.
  - High phase, DIV cycles: sclk=1, sdata unchanged.
  - At the end of the high phase, either advance to the next bit (sclk→0 and sdata changes on the same edge) or, after bit WIDTH, go to LATCH.
- LATCH: DIV cycles with sen=1, sclk=0, sdata=0. Then go to IDLE with busy=0 and done=1 for one cycle.
- A req seen in SHIFT or LATCH sets pending.
- IDLE: pending or req loads on the first IDLE edge. The load takes the current data, not the value at the time of the request.
- Half-period counter is ceil(log2(DIV+1)) bits; bit counter is ceil(log2(WIDTH+1)) bits. Neither may wrap inside a transfer.
- sclr=0 while rst is asserted and for the first cycle after release; 1 otherwise.

## Timing
- Reset values: sclk=0, sdata=0, sen=0, busy=0, done=0, sclr=0, pending=0, last_sent=0, state=IDLE.
- rst mid-transfer aborts on that edge: outputs go to reset values and no done is issued.
- Latency: req at edge k gives busy=1 and the first bit on sdata at k+1.
- First sclk rising edge comes at k+1+DIV.
- busy stays high for exactly 2·DIV·WIDTH + DIV cycles. done rises in the first cycle busy=0.
- Back-to-back: a pending transfer reloads at the edge where done is high. The gap is exactly one busy=0 cycle.
- start held high gives continuous refresh: transfers repeat every 2·DIV·WIDTH + DIV + 1 cycles.
- sdata changes only on sclk falling edges or at entry to SHIFT/LATCH. Setup and hold around each sclk rise are each DIV cycles.
- sclk and sen are never both 1.
- AUTO=1 and data≠0 at reset release starts a transfer on the first edge after release.

## Test plan
- WIDTH=8, DIV=2, MSB_FIRST=1, AUTO=1, data=8'hA5 after reset:
  - sclk rises at cycles 3,7,…,31 after load.
  - Bits sampled at those rises are 1,0,1,0,0,1,0,1.
  - sen high for 2 cycles; busy high for 34 cycles; one done pulse.
- MSB_FIRST=0, data=8'h01: sampled bits are 1,0,0,0,0,0,0,0.
- Change data 8'hA5→8'h3C at mid-bit 3, then →8'hFF two cycles later:
  - The current transfer finishes sending A5 unchanged.
  - After one idle cycle, exactly one new transfer sends FF. No 3C transfer occurs.
- AUTO=0, data held at 8'h5A: no activity. A one-cycle start pulse gives exactly one transfer of 5A.
- Assert rst at cycle 10 of a transfer: sclk, sdata, sen, busy and sclr read 0 on the next cycle, and no done pulse appears.
- DIV=1, WIDTH=64, start held high:
  - busy is high for 129 cycles, then low for 1 cycle, repeating.
  - sclk toggles every cycle during SHIFT.

Source files
------------

// File: rtl/seg_p2s_stream.sv
// Parallel-to-serial driver for the seven-segment shift-register chain.
// Snapshots a WIDTH-bit pattern, shifts it out on a registered sclk, then strobes sen.
module seg_p2s_stream #(
   parameter int WIDTH     = 64,
   parameter int DIV       = 1,
   parameter int MSB_FIRST = 1,
   parameter int AUTO      = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data,
   input  logic             start,
   output logic             sclk,
   output logic             sdata,
   output logic             sclr,
   output logic             sen,
   output logic             busy,
   output logic             done
);
   localparam int HW = $clog2(DIV + 1);
   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [HW-1:0] HLAST = HW'(DIV - 1);
   localparam bit MSB = (MSB_FIRST != 0);

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] last_sent;
   logic [HW-1:0]    hcnt;
   logic [BW-1:0]    bitcnt;
   logic             pending;
   logic             rst_d;
   logic             req;

   assign req = start | ((AUTO != 0) && (data != last_sent));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shreg     <= '0;
         last_sent <= '0;
         hcnt      <= '0;
         bitcnt    <= '0;
         pending   <= 1'b0;
         rst_d     <= 1'b1;
         sclk      <= 1'b0;
         sdata     <= 1'b0;
         sclr      <= 1'b0;
         sen       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         // rst_d keeps the chain cleared for one extra cycle after release
         rst_d <= 1'b0;
         sclr  <= ~rst_d;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (req || pending) begin
                  state     <= SHIFT;
                  shreg     <= data;
                  last_sent <= data;
                  bitcnt    <= BW'(WIDTH);
                  hcnt      <= '0;
                  pending   <= 1'b0;
                  busy      <= 1'b1;
                  sclk      <= 1'b0;
                  sdata     <= MSB ? data[WIDTH-1] : data[0];
               end
            end
            SHIFT: begin
               if (req) pending <= 1'b1;
               if (hcnt == HLAST) begin
                  hcnt <= '0;
                  if (!sclk) begin
                     sclk <= 1'b1;
                  end else if (bitcnt == BW'(1)) begin
                     state <= LATCH;
                     sclk  <= 1'b0;
                     sdata <= 1'b0;
                     sen   <= 1'b1;
                  end else begin
                     // next bit appears on the same edge sclk falls
                     sclk   <= 1'b0;
                     bitcnt <= bitcnt - BW'(1);
                     if (MSB) begin
                        sdata <= shreg[WIDTH-2];
                        shreg <= shreg << 1;
                     end else begin
                        sdata <= shreg[1];
                        shreg <= shreg >> 1;
                     end
                  end
               end else begin
                  hcnt <= hcnt + HW'(1);
               end
            end
            LATCH: begin
               if (req) pending <= 1'b1;
               if (hcnt == HLAST) begin
                  hcnt  <= '0;
                  state <= IDLE;
                  sen   <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  hcnt <= hcnt + HW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seg_p2s_stream.sv
// Bench for seg_p2s_stream: three configurations share clk/rst; a monitor
// reconstructs each transfer from the pins and compares against expected patterns.
module tb_seg_p2s_stream;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0]  data0 = '0, data1 = '0;
   logic [63:0] data2 = '0;
   logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
   logic [2:0] sclk_v, sdata_v, sclr_v, sen_v, busy_v, done_v;

   int compared = 0;
   int mism = 0;

   always #5 clk = ~clk;

   // 0: W8 DIV2 MSB-first AUTO ; 1: W8 DIV2 LSB-first start-only ; 2: W64 DIV1 start-only
   seg_p2s_stream #(.WIDTH(8), .DIV(2), .MSB_FIRST(1), .AUTO(1)) u0 (
      .clk(clk), .rst(rst), .data(data0), .start(start0),
      .sclk(sclk_v[0]), .sdata(sdata_v[0]), .sclr(sclr_v[0]), .sen(sen_v[0]),
      .busy(busy_v[0]), .done(done_v[0]));
   seg_p2s_stream #(.WIDTH(8), .DIV(2), .MSB_FIRST(0), .AUTO(0)) u1 (
      .clk(clk), .rst(rst), .data(data1), .start(start1),
      .sclk(sclk_v[1]), .sdata(sdata_v[1]), .sclr(sclr_v[1]), .sen(sen_v[1]),
      .busy(busy_v[1]), .done(done_v[1]));
   seg_p2s_stream #(.WIDTH(64), .DIV(1), .MSB_FIRST(1), .AUTO(0)) u2 (
      .clk(clk), .rst(rst), .data(data2), .start(start2),
      .sclk(sclk_v[2]), .sdata(sdata_v[2]), .sclr(sclr_v[2]), .sen(sen_v[2]),
      .busy(busy_v[2]), .done(done_v[2]));

   // pin-level monitor: per-transfer bit capture, rise positions, busy/sen lengths, gaps
   logic [63:0] cap[3], rec_cap[3];
   int bcyc[3], nbits[3], first_r[3], last_r[3], senc[3], gap[3];
   int rec_n[3], rec_busy[3], rec_sen[3], rec_first[3], rec_last[3], rec_gap[3];
   int dcnt[3], ovl[3];
   logic psclk[3], pbusy[3];

   initial begin
      for (int d = 0; d < 3; d++) begin
         cap[d] = '0; rec_cap[d] = '0; bcyc[d] = 0; nbits[d] = 0; first_r[d] = 0;
         last_r[d] = 0; senc[d] = 0; gap[d] = 0; rec_n[d] = 0; rec_busy[d] = 0;
         rec_sen[d] = 0; rec_first[d] = 0; rec_last[d] = 0; rec_gap[d] = 0;
         dcnt[d] = 0; ovl[d] = 0; psclk[d] = 1'b0; pbusy[d] = 1'b0;
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (busy_v[d] && !pbusy[d]) begin
            bcyc[d] <= 1; nbits[d] <= 0; cap[d] <= '0; senc[d] <= 0;
            first_r[d] <= 0; last_r[d] <= 0; rec_gap[d] <= gap[d]; gap[d] <= 0;
         end else begin
            if (busy_v[d]) bcyc[d] <= bcyc[d] + 1;
            if (!busy_v[d]) gap[d] <= gap[d] + 1;
            if (sclk_v[d] && !psclk[d]) begin
               cap[d]   <= {cap[d][62:0], sdata_v[d]};
               nbits[d] <= nbits[d] + 1;
               if (first_r[d] == 0) first_r[d] <= bcyc[d] + 1;
               last_r[d] <= bcyc[d] + 1;
            end
            if (sen_v[d]) senc[d] <= senc[d] + 1;
         end
         if (sclk_v[d] && sen_v[d]) ovl[d] <= ovl[d] + 1;
         if (done_v[d]) begin
            dcnt[d] <= dcnt[d] + 1;
            rec_cap[d] <= cap[d]; rec_n[d] <= nbits[d]; rec_busy[d] <= bcyc[d];
            rec_sen[d] <= senc[d]; rec_first[d] <= first_r[d]; rec_last[d] <= last_r[d];
         end
         psclk[d] <= sclk_v[d];
         pbusy[d] <= busy_v[d];
      end
   end

   // expected on-wire bit order, oldest bit ends up most significant
   function automatic logic [63:0] seq(input logic [63:0] v, input int w, input bit msb);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < w; i++) r = {r[62:0], (msb ? v[w-1-i] : v[i])};
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mism++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input int d, input string tag);
      int s;
      s = dcnt[d];
      for (int i = 0; i < 400 && dcnt[d] == s; i++) cyc(1);
      chk(tag, 64'(dcnt[d] - s), 64'd1);
   endtask

   task automatic check_xfer8(input int d, input logic [7:0] v, input bit msb, input string tag);
      chk({tag, "_bits"}, rec_cap[d], seq(64'(v), 8, msb));
      chk({tag, "_nbits"}, 64'(rec_n[d]), 64'd8);
      chk({tag, "_busy"}, 64'(rec_busy[d]), 64'd34);
      chk({tag, "_sen"}, 64'(rec_sen[d]), 64'd2);
   endtask

   initial begin
      logic [7:0] v1, v2;
      int s;

      cyc(3);
      chk("reset_outs", 64'({sclk_v[0], sdata_v[0], sen_v[0], busy_v[0], done_v[0], sclr_v[0]}), 64'd0);

      // AUTO with nonzero data at release starts on the first edge
      data0 = 8'hA5;
      rst = 1'b0;
      cyc(1);
      chk("first_bit", 64'({busy_v[0], sclk_v[0], sdata_v[0]}), 64'b101);
      chk("sclr_hold", 64'(sclr_v[0]), 64'd0);
      cyc(1);
      chk("sclr_rel", 64'(sclr_v[0]), 64'd1);
      wait_done(0, "a5_done");
      check_xfer8(0, 8'hA5, 1'b1, "a5");
      chk("a5_first_rise", 64'(rec_first[0]), 64'd3);
      chk("a5_last_rise", 64'(rec_last[0]), 64'd31);
      cyc(1);
      chk("done_pulse", 64'({done_v[0], busy_v[0]}), 64'd0);
      s = dcnt[0];
      cyc(20);
      chk("a5_no_repeat", 64'(dcnt[0] - s), 64'd0);

      // queued change: A5 in flight, 3C then FF arrive; only FF follows
      data0 = 8'h00;
      wait_done(0, "zero_done");
      data0 = 8'hA5;
      cyc(10);
      data0 = 8'h3C;
      cyc(2);
      data0 = 8'hFF;
      wait_done(0, "mid_a5_done");
      check_xfer8(0, 8'hA5, 1'b1, "mid_a5");
      wait_done(0, "mid_ff_done");
      check_xfer8(0, 8'hFF, 1'b1, "mid_ff");
      chk("mid_gap", 64'(rec_gap[0]), 64'd1);
      s = dcnt[0];
      cyc(50);
      chk("mid_no_3c", 64'(dcnt[0] - s), 64'd0);

      // random idle loads and random mid-transfer changes
      for (int i = 0; i < 6; i++) begin
         v1 = 8'($urandom_range(255, 0));
         if (v1 == data0) v1 = v1 ^ 8'h01;
         data0 = v1;
         wait_done(0, "rnd_done");
         check_xfer8(0, v1, 1'b1, "rnd");
      end
      for (int i = 0; i < 3; i++) begin
         v1 = 8'($urandom_range(255, 0));
         if (v1 == data0) v1 = v1 ^ 8'h80;
         v2 = v1 ^ 8'($urandom_range(255, 1));
         data0 = v1;
         cyc(int'($urandom_range(30, 3)));
         data0 = v2;
         wait_done(0, "rmid1_done");
         check_xfer8(0, v1, 1'b1, "rmid1");
         wait_done(0, "rmid2_done");
         check_xfer8(0, v2, 1'b1, "rmid2");
         chk("rmid_gap", 64'(rec_gap[0]), 64'd1);
      end

      // start-only, LSB first
      data1 = 8'h01;
      cyc(20);
      chk("auto0_idle", 64'({busy_v[1], 32'(dcnt[1])}), 64'd0);
      start1 = 1'b1; cyc(1); start1 = 1'b0;
      wait_done(1, "lsb01_done");
      check_xfer8(1, 8'h01, 1'b0, "lsb01");
      data1 = 8'h5A;
      cyc(5);
      start1 = 1'b1; cyc(1); start1 = 1'b0;
      wait_done(1, "lsb5a_done");
      check_xfer8(1, 8'h5A, 1'b0, "lsb5a");
      s = dcnt[1];
      cyc(40);
      chk("lsb5a_once", 64'(dcnt[1] - s), 64'd0);

      // reset mid-transfer aborts with no done
      data1 = 8'hC3;
      start1 = 1'b1; cyc(1); start1 = 1'b0;
      cyc(9);
      s = dcnt[1];
      rst = 1'b1;
      cyc(1);
      chk("abort_outs", 64'({sclk_v[1], sdata_v[1], sen_v[1], busy_v[1], sclr_v[1], done_v[1]}), 64'd0);
      rst = 1'b0;
      cyc(60);
      chk("abort_no_done", 64'(dcnt[1] - s), 64'd0);

      // continuous refresh at DIV=1, WIDTH=64
      data2 = {32'($urandom), 32'($urandom)};
      start2 = 1'b1;
      wait_done(2, "cont_done0");
      for (int i = 0; i < 2; i++) begin
         wait_done(2, "cont_done");
         chk("cont_busy", 64'(rec_busy[2]), 64'd129);
         chk("cont_gap", 64'(rec_gap[2]), 64'd1);
         chk("cont_nbits", 64'(rec_n[2]), 64'd64);
         chk("cont_rises", 64'({32'(rec_first[2]), 32'(rec_last[2])}), {32'd2, 32'd128});
         chk("cont_bits", rec_cap[2], seq(data2, 64, 1'b1));
      end
      start2 = 1'b0;
      cyc(300);
      s = dcnt[2];
      cyc(200);
      chk("cont_stop", 64'({busy_v[2], 32'(dcnt[2] - s)}), 64'd0);

      for (int d = 0; d < 3; d++) chk("sclk_sen_overlap", 64'(ovl[d]), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end
endmodule
